bp_stat_unit: RTL and testbench
===============================

Name: bp_stat_unit

Overview:
Branch-prediction profiling peripheral attached to the OTTER MCU IOBUS, downstream of the MCU and branch predictor. Each cycle it watches the same commit stream the predictor sees (data_valid/pcSource/opcode/pc) plus the predictor's prediction, and classifies each retired control-flow instruction. It keeps saturating event counters and a mispredict-streak tracker, all readable and controllable through memory-mapped IOBUS registers. Software uses it to measure predictor accuracy without halting the core.

Parameters:
BASE_ADDR, 32'h1100_0200, word-aligned base of the 8-word register window
CNT_W, 32, width of every event counter (8..32)
FREEZE_ON_SAT, 1, 1 = all counting stops when any counter saturates

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
data_valid  in  1  retire strobe (MCU pcWrite); one instruction commits when high
pcSource  in  3  next-PC select: 0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc
opcode  in  7  opcode of the committing instruction (ir[6:0])
pc  in  32  address of the committing instruction
pred_valid  in  1  predictor holds a prediction for pc
pred_taken  in  1  predicted direction, valid with pred_valid
IOBUS_ADDR  in  32  bus address
IOBUS_WR  in  1  bus write strobe
IOBUS_OUT  in  32  bus write data (MCU output)
rd_data  out  32  registered read data for IOBUS_ADDR (into MCU IOBUS_IN mux)
sat_irq  out  1  high while in SAT state and ctrl.irq_en=1

Behaviour:
- Register map (offset from BASE_ADDR): 0x00 CTRL {irq_en[2], clear[1] (write-1 self-clearing), en[0]}; 0x04 BRANCH_CNT; 0x08 TAKEN_CNT; 0x0C MISPRED_CNT; 0x10 NOPRED_CNT; 0x14 JUMP_CNT (jal+jalr); 0x18 MAX_STREAK; 0x1C STATUS {state[1:0]}. Counters read-only and zero-extended to 32 bits.
- Event, evaluated only when data_valid=1 and state=RUN:
  - branch = opcode 7'b1100011; taken = branch & (pcSource==2).
  - branch & pred_valid & (pred_taken != taken) -> mispredict; branch & !pred_valid -> nopred.
  - opcode 7'b1101111 or 7'b1100111 -> JUMP_CNT++.
  - pcSource 4/5 (trap/mret) commits are ignored entirely.
- Streak: cur_streak increments on mispredict; resets to 0 on a correctly predicted branch; MAX_STREAK = max(MAX_STREAK, cur_streak+1) on the same-cycle mispredict.
- Counters saturate at all-ones; never wrap.
- FSM states:
  - IDLE (00): reset state.
  - RUN (01): entered from IDLE when en is written 1; returns to IDLE when en is written 0.
  - SAT (10): entered from RUN when any counter hits max and FREEZE_ON_SAT=1; counting stops. If FREEZE_ON_SAT=0, SAT is never entered and saturated counters simply hold.
  - Clear from any state zeroes all counters and cur_streak, then goes to RUN if en=1, else IDLE.
- CTRL write takes effect next cycle. Write with en=1 and clear=1 in the same write: clear wins for counters; state becomes RUN.
- Event and clear in the same cycle: clear wins; the event is dropped.
- Reads: rd_data is registered from IOBUS_ADDR with 1-cycle latency. Addresses outside the window, or unaligned, read 0. Writes outside the window are ignored. Writes to counter offsets are ignored.
- Reset: all counters, cur_streak, CTRL, rd_data, and sat_irq are 0; state is IDLE. Reset mid-count discards all state.
- sat_irq is combinational from state and irq_en; no additional latency.

Decomposition:
- Package bp_stat_pkg: pcSource encodings (PCS_PC4..PCS_MEPC), opcode constants (OP_BRANCH, OP_JAL, OP_JALR), register offsets, state enum stat_state_t.
- One natural sub-module: sat_counter (width-parameterised, inc/clr/hold, sat flag), instantiated six times (five event counters plus cur_streak).

Test Plan:
- Reset, then read all 8 offsets -> all 0; STATUS=0 (IDLE); sat_irq=0.
- en=1; retire 10 branches, opcode 1100011: 6 with pcSource=2 (pred_taken=1), 4 with pcSource=0 (pred_taken=1), pred_valid=1 -> BRANCH=10, TAKEN=6, MISPRED=4, NOPRED=0.
- Sequence mispredict×3, correct, mispredict×2 -> MAX_STREAK=3; then a further mispredict×2 (streak reaches 4) -> MAX_STREAK=4.
- CNT_W=8, FREEZE_ON_SAT=1, irq_en=1: retire 255 jal -> JUMP=255, STATUS=SAT, sat_irq=1; a further branch leaves BRANCH unchanged.
- Write CTRL=3 in the same cycle as a branch commit -> all counters 0, STATUS=RUN, branch not counted.
- Trap commit (pcSource=4, branch opcode) and a data_valid=0 cycle -> no counter changes. Read of BASE_ADDR+0x20 -> 0, returned one cycle after address.

Source files
------------

// File: rtl/bp_stat_pkg.sv
// Shared encodings for the branch-prediction statistics unit: commit-stream
// decode constants, register window offsets and the control FSM states.
package bp_stat_pkg;

  // Next-PC select values driven by the MCU alongside each commit
  localparam logic [2:0] PCS_PC4    = 3'd0;
  localparam logic [2:0] PCS_JALR   = 3'd1;
  localparam logic [2:0] PCS_BRANCH = 3'd2;
  localparam logic [2:0] PCS_JAL    = 3'd3;
  localparam logic [2:0] PCS_MTVEC  = 3'd4;
  localparam logic [2:0] PCS_MEPC   = 3'd5;

  // RV32I control-flow opcodes (ir[6:0])
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Byte offsets inside the 8-word register window
  localparam logic [4:0] REG_CTRL       = 5'h00;
  localparam logic [4:0] REG_BRANCH_CNT = 5'h04;
  localparam logic [4:0] REG_TAKEN_CNT  = 5'h08;
  localparam logic [4:0] REG_MISPRED    = 5'h0C;
  localparam logic [4:0] REG_NOPRED     = 5'h10;
  localparam logic [4:0] REG_JUMP_CNT   = 5'h14;
  localparam logic [4:0] REG_MAX_STREAK = 5'h18;
  localparam logic [4:0] REG_STATUS     = 5'h1C;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLEAR_BIT = 1;
  localparam int CTRL_IRQ_BIT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SAT  = 2'b10
  } stat_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear has priority over increment, and the value
// holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX_VAL = '1;
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == MAX_VAL);
  assign cnt = cnt_q;

  // Next count: clear, else increment unless already saturated
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_stat_unit.sv
// Branch-prediction profiling peripheral on the OTTER IOBUS. Classifies each
// retired control-flow instruction against the predictor's guess, keeps
// saturating event counters and a mispredict-streak record, and exposes
// them through an 8-word memory-mapped window with registered read data.
module bp_stat_unit
  import bp_stat_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h1100_0200,
  parameter int          CNT_W         = 32,
  parameter bit          FREEZE_ON_SAT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        data_valid,
  input  logic [2:0]  pcSource,
  input  logic [6:0]  opcode,
  input  logic [31:0] pc,
  input  logic        pred_valid,
  input  logic        pred_taken,
  input  logic [31:0] IOBUS_ADDR,
  input  logic        IOBUS_WR,
  input  logic [31:0] IOBUS_OUT,
  output logic [31:0] rd_data,
  output logic        sat_irq
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stat_state_t state_q;
  logic        en_q, en_d, irq_en_q, irq_en_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] max_streak_q, max_streak_d;

  logic [31:0] offset;
  logic        in_win, ctrl_wr, clr;
  logic        is_branch, is_jump, is_trap, frozen, live, taken;
  logic        ev_branch, ev_taken, ev_mis, ev_nopred, ev_hit, ev_jump;
  logic [CNT_W-1:0] streak_next;

  logic [CNT_W-1:0] cnt_branch, cnt_taken, cnt_mis, cnt_nopred, cnt_jump, cnt_streak;
  logic sat_branch, sat_taken, sat_mis, sat_nopred, sat_jump, sat_streak;
  logic any_sat;

  // The commit pc is carried on the bus for future per-address profiling
  logic unused_bits;
  assign unused_bits = ^{pc, IOBUS_OUT[31:3]};

  assign any_sat = sat_branch | sat_taken | sat_mis | sat_nopred | sat_jump;

  // Bus address decode and CTRL write/clear strobes
  always_comb begin
    offset  = IOBUS_ADDR - BASE_ADDR;
    in_win  = (offset[31:5] == 27'd0) && (offset[1:0] == 2'b00);
    ctrl_wr = IOBUS_WR && in_win && (offset[4:0] == REG_CTRL);
    clr     = ctrl_wr && IOBUS_OUT[CTRL_CLEAR_BIT];
  end

  // Classify the committing instruction; only counted while running unfrozen
  always_comb begin
    is_branch = (opcode == OP_BRANCH);
    is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    is_trap   = (pcSource == PCS_MTVEC) || (pcSource == PCS_MEPC);
    frozen    = FREEZE_ON_SAT && any_sat;
    live      = data_valid && !is_trap && (state_q == ST_RUN) && !frozen;
    taken     = (pcSource == PCS_BRANCH);
    ev_branch = live && is_branch;
    ev_taken  = ev_branch && taken;
    ev_mis    = ev_branch && pred_valid && (pred_taken != taken);
    ev_hit    = ev_branch && pred_valid && (pred_taken == taken);
    ev_nopred = ev_branch && !pred_valid;
    ev_jump   = live && is_jump;
  end

  sat_counter #(.W(CNT_W)) u_branch (.clk(CLK), .rst(RST), .clr(clr), .inc(ev_branch), .cnt(cnt_branch), .sat(sat_branch));
  sat_counter #(.W(CNT_W)) u_taken  (.clk(CLK), .rst(RST), .clr(clr), .inc(ev_taken),  .cnt(cnt_taken),  .sat(sat_taken));
  sat_counter #(.W(CNT_W)) u_mis    (.clk(CLK), .rst(RST), .clr(clr), .inc(ev_mis),    .cnt(cnt_mis),    .sat(sat_mis));
  sat_counter #(.W(CNT_W)) u_nopred (.clk(CLK), .rst(RST), .clr(clr), .inc(ev_nopred), .cnt(cnt_nopred), .sat(sat_nopred));
  sat_counter #(.W(CNT_W)) u_jump   (.clk(CLK), .rst(RST), .clr(clr), .inc(ev_jump),   .cnt(cnt_jump),   .sat(sat_jump));
  // A correctly predicted branch ends the current mispredict run
  sat_counter #(.W(CNT_W)) u_streak (.clk(CLK), .rst(RST), .clr(clr | ev_hit), .inc(ev_mis), .cnt(cnt_streak), .sat(sat_streak));

  // Longest streak: compare against the streak length including this mispredict
  always_comb begin
    streak_next  = sat_streak ? cnt_streak : cnt_streak + ONE;
    max_streak_d = max_streak_q;
    if (clr) begin
      max_streak_d = '0;
    end else if (ev_mis && (streak_next > max_streak_q)) begin
      max_streak_d = streak_next;
    end
  end

  // CTRL fields; clear is a strobe and is never stored
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      en_d     = IOBUS_OUT[CTRL_EN_BIT];
      irq_en_d = IOBUS_OUT[CTRL_IRQ_BIT];
    end
  end

  // Read mux; anything outside the window or unaligned returns zero
  always_comb begin
    rd_data_d = '0;
    if (in_win) begin
      case (offset[4:0])
        REG_CTRL:       rd_data_d = {29'd0, irq_en_q, 1'b0, en_q};
        REG_BRANCH_CNT: rd_data_d = 32'(cnt_branch);
        REG_TAKEN_CNT:  rd_data_d = 32'(cnt_taken);
        REG_MISPRED:    rd_data_d = 32'(cnt_mis);
        REG_NOPRED:     rd_data_d = 32'(cnt_nopred);
        REG_JUMP_CNT:   rd_data_d = 32'(cnt_jump);
        REG_MAX_STREAK: rd_data_d = 32'(max_streak_q);
        REG_STATUS:     rd_data_d = {30'd0, state_q};
        default:        rd_data_d = '0;
      endcase
    end
  end

  // Control, streak-record and read-data registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q         <= 1'b0;
      irq_en_q     <= 1'b0;
      max_streak_q <= '0;
      rd_data_q    <= '0;
    end else begin
      en_q         <= en_d;
      irq_en_q     <= irq_en_d;
      max_streak_q <= max_streak_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Run-control FSM; clear overrides every state, SAT is left only via clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else if (clr) begin
      state_q <= IOBUS_OUT[CTRL_EN_BIT] ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ctrl_wr && IOBUS_OUT[CTRL_EN_BIT]) state_q <= ST_RUN;
        ST_RUN: begin
          if (ctrl_wr && !IOBUS_OUT[CTRL_EN_BIT]) state_q <= ST_IDLE;
          else if (frozen)                        state_q <= ST_SAT;
        end
        ST_SAT:  state_q <= ST_SAT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_data = rd_data_q;
  assign sat_irq = (state_q == ST_SAT) && irq_en_q;

endmodule

// File: tb/tb_bp_stat_unit.sv
// Self-checking bench for bp_stat_unit (8-bit counters, freeze on saturation):
// directed scenarios with fixed expectations, then random commit/bus traffic
// compared every cycle against a behavioural model of the register window.
module tb_bp_stat_unit;

  localparam logic [31:0] BASE  = 32'h1100_0200;
  localparam int          CNT_W = 8;
  localparam int          MAXV  = (1 << CNT_W) - 1;
  localparam logic [6:0]  OPB   = 7'b1100011;
  localparam logic [6:0]  OPJ   = 7'b1101111;
  localparam logic [6:0]  OPJR  = 7'b1100111;

  logic        CLK, RST;
  logic        data_valid, pred_valid, pred_taken, IOBUS_WR, sat_irq;
  logic [2:0]  pcSource;
  logic [6:0]  opcode;
  logic [31:0] pc, IOBUS_ADDR, IOBUS_OUT, rd_data;

  bp_stat_unit #(.BASE_ADDR(BASE), .CNT_W(CNT_W), .FREEZE_ON_SAT(1'b1)) dut (
    .CLK(CLK), .RST(RST), .data_valid(data_valid), .pcSource(pcSource),
    .opcode(opcode), .pc(pc), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_WR(IOBUS_WR), .IOBUS_OUT(IOBUS_OUT),
    .rd_data(rd_data), .sat_irq(sat_irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: counters 0 branch, 1 taken, 2 mispredict, 3 nopred, 4 jump
  int m_cnt[5];
  int m_cur, m_max, m_state;   // m_state: 0 idle, 1 run, 2 saturated
  bit m_en, m_irq, exp_irq;

  function automatic int inc_sat(input int v);
    return (v < MAXV) ? v + 1 : MAXV;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off > 32'd31 || off[1:0] != 2'b00) return 32'h0;
    case (off[4:2])
      3'd0:    return {29'h0, m_irq, 1'b0, m_en};
      3'd6:    return 32'(m_max);
      3'd7:    return 32'(m_state);
      default: return 32'(m_cnt[int'(off[4:2]) - 1]);
    endcase
  endfunction

  task automatic model_update();
    bit wr_ctrl, clear, frozen, live, tk;
    if (RST) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_cur = 0; m_max = 0; m_state = 0; m_en = 0; m_irq = 0; exp_irq = 0;
      return;
    end
    wr_ctrl = IOBUS_WR && (IOBUS_ADDR == BASE);
    clear   = wr_ctrl && IOBUS_OUT[1];
    frozen  = 0;
    foreach (m_cnt[k]) if (m_cnt[k] == MAXV) frozen = 1;
    live = (m_state == 1) && !frozen && data_valid && pcSource != 3'd4 && pcSource != 3'd5;
    tk   = (pcSource == 3'd2);
    if (clear) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_cur = 0; m_max = 0;
    end else if (live) begin
      if (opcode == OPB) begin
        m_cnt[0] = inc_sat(m_cnt[0]);
        if (tk) m_cnt[1] = inc_sat(m_cnt[1]);
        if (!pred_valid) m_cnt[3] = inc_sat(m_cnt[3]);
        else if (pred_taken != tk) begin
          m_cnt[2] = inc_sat(m_cnt[2]);
          m_cur    = inc_sat(m_cur);
          if (m_cur > m_max) m_max = m_cur;
        end else m_cur = 0;
      end
      if (opcode == OPJ || opcode == OPJR) m_cnt[4] = inc_sat(m_cnt[4]);
    end
    if (clear)                                          m_state = IOBUS_OUT[0] ? 1 : 0;
    else if (m_state == 0 && wr_ctrl && IOBUS_OUT[0])   m_state = 1;
    else if (m_state == 1 && wr_ctrl && !IOBUS_OUT[0])  m_state = 0;
    else if (m_state == 1 && frozen)                    m_state = 2;
    if (wr_ctrl) begin
      m_en  = IOBUS_OUT[0];
      m_irq = IOBUS_OUT[2];
    end
    exp_irq = (m_state == 2) && m_irq;
  endtask

  // One clock: predict, advance, then compare read data and irq after the edge
  task automatic step();
    logic [31:0] exp_rd;
    exp_rd = RST ? 32'h0 : model_read(IOBUS_ADDR);
    model_update();
    @(posedge CLK);
    #1;
    check({phase, ":rd_data"}, rd_data, exp_rd);
    check({phase, ":sat_irq"}, {31'h0, sat_irq}, {31'h0, exp_irq});
  endtask

  task automatic set_idle();
    data_valid = 0; pcSource = 3'd0; opcode = 7'h13;
    pred_valid = 0; pred_taken = 0; IOBUS_WR = 0; IOBUS_OUT = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr; IOBUS_WR = 1; IOBUS_OUT = data;
    step();
    IOBUS_WR = 0; IOBUS_OUT = 32'h0;
  endtask

  task automatic retire(input logic [6:0] op, input logic [2:0] pcs, input logic pv, input logic pt);
    data_valid = 1; opcode = op; pcSource = pcs; pred_valid = pv; pred_taken = pt;
    pc = pc + 32'd4;
    step();
    data_valid = 0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] val);
    IOBUS_ADDR = addr;
    step();
    val = rd_data;
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] v;
    read_reg(BASE + 32'(off), v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [31:0] v;
    logic [6:0]  ops[5];
    ops = '{OPB, OPB, OPJ, OPJR, 7'b0110011};
    pc = 32'h0000_1000; IOBUS_ADDR = BASE;
    set_idle();
    RST = 1;
    phase = "reset";
    step(); step();
    RST = 0;

    // Reset state of the whole window
    for (int i = 0; i < 8; i++) begin
      read_reg(BASE + 32'(4 * i), v);
      check($sformatf("reset_reg%0d", i), v, 32'h0);
    end
    check("reset_irq", {31'h0, sat_irq}, 32'h0);

    // Ten predicted branches: six taken and correct, four not-taken mispredicts
    phase = "basic";
    bus_write(BASE, 32'h1);
    for (int i = 0; i < 6; i++) retire(OPB, 3'd2, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) retire(OPB, 3'd0, 1'b1, 1'b1);
    expect_reg("branch10", 5'h04, 32'd10);
    expect_reg("taken6",   5'h08, 32'd6);
    expect_reg("mispred4", 5'h0C, 32'd4);
    expect_reg("nopred0",  5'h10, 32'd0);
    expect_reg("status_run", 5'h1C, 32'd1);

    // Streak record: 3 miss, hit, 2 miss -> 3; two more misses -> 4
    phase = "streak";
    bus_write(BASE, 32'h3);
    for (int i = 0; i < 3; i++) retire(OPB, 3'd0, 1'b1, 1'b1);
    retire(OPB, 3'd2, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) retire(OPB, 3'd0, 1'b1, 1'b1);
    expect_reg("max_streak3", 5'h18, 32'd3);
    for (int i = 0; i < 2; i++) retire(OPB, 3'd0, 1'b1, 1'b1);
    expect_reg("max_streak4", 5'h18, 32'd4);
    expect_reg("mispred7", 5'h0C, 32'd7);

    // Clear and en in the same cycle as a branch commit: branch is dropped
    phase = "clr_evt";
    data_valid = 1; opcode = OPB; pcSource = 3'd2; pred_valid = 1; pred_taken = 1;
    bus_write(BASE, 32'h3);
    set_idle();
    expect_reg("clr_branch0", 5'h04, 32'd0);
    expect_reg("clr_mis0",    5'h0C, 32'd0);
    expect_reg("clr_max0",    5'h18, 32'd0);
    expect_reg("clr_status",  5'h1C, 32'd1);

    // Trap commit and an invalid cycle change nothing; counter writes ignored
    phase = "ignore";
    retire(OPB, 3'd2, 1'b1, 1'b1);
    retire(OPB, 3'd4, 1'b1, 1'b0);
    data_valid = 0; opcode = OPB; pcSource = 3'd2; pred_valid = 1; pred_taken = 0;
    step();
    set_idle();
    bus_write(BASE + 32'h4, 32'hFF);
    expect_reg("ign_branch1", 5'h04, 32'd1);
    expect_reg("ign_taken1",  5'h08, 32'd1);
    expect_reg("ign_mis0",    5'h0C, 32'd0);
    read_reg(BASE + 32'h20, v);
    check("oob_read", v, 32'h0);
    read_reg(BASE + 32'h5, v);
    check("unaligned_read", v, 32'h0);

    // Saturation: 255 jumps with irq enabled freeze the unit
    phase = "sat";
    bus_write(BASE, 32'h7);
    for (int i = 0; i < MAXV; i++) retire(OPJ, 3'd3, 1'b0, 1'b0);
    expect_reg("jump255", 5'h14, 32'd255);
    expect_reg("status_sat", 5'h1C, 32'd2);
    check("sat_irq_on", {31'h0, sat_irq}, 32'h1);
    retire(OPB, 3'd2, 1'b1, 1'b1);
    expect_reg("sat_branch0", 5'h04, 32'd0);
    bus_write(BASE, 32'h3);
    expect_reg("unsat_status", 5'h1C, 32'd1);
    check("sat_irq_off", {31'h0, sat_irq}, 32'h0);

    // Random commit stream with occasional bus writes, checked every cycle
    phase = "rand";
    for (int n = 0; n < 3000; n++) begin
      int k;
      set_idle();
      k = $urandom_range(0, 11);
      if (k < 8)       IOBUS_ADDR = BASE + 32'(4 * k);
      else if (k == 8) IOBUS_ADDR = BASE + 32'h20;
      else if (k == 9) IOBUS_ADDR = BASE + 32'(4 * $urandom_range(0, 7) + 1);
      else if (k == 10) IOBUS_ADDR = BASE - 32'h4;
      else             IOBUS_ADDR = 32'h0;
      k = $urandom_range(0, 99);
      if (k < 4) begin
        IOBUS_WR   = 1;
        IOBUS_ADDR = BASE;
        IOBUS_OUT  = {29'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 3) != 0)};
        if (m_state == 2) IOBUS_OUT[1] = 1'b1;
      end else if (k < 6) begin
        IOBUS_WR   = 1;
        IOBUS_ADDR = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * $urandom_range(1, 7)) : BASE + 32'h40;
        IOBUS_OUT  = $urandom;
      end
      data_valid = ($urandom_range(0, 3) != 0);
      opcode     = ops[$urandom_range(0, 4)];
      pcSource   = 3'($urandom_range(0, 5));
      pred_valid = ($urandom_range(0, 4) != 0);
      pred_taken = 1'($urandom_range(0, 1));
      pc         = pc + 32'd4;
      step();
    end

    // Reset in the middle of counting discards everything
    phase = "midreset";
    set_idle();
    data_valid = 1; opcode = OPB; pcSource = 3'd2;
    RST = 1;
    step();
    RST = 0;
    set_idle();
    expect_reg("mr_branch0", 5'h04, 32'd0);
    expect_reg("mr_ctrl0",   5'h00, 32'd0);
    expect_reg("mr_status0", 5'h1C, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
